// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- central pipeline controller for the 5-stage RV32 core.
//
// Turns per-stage hold requests and the EX-stage branch/jump result into the
// per-stage freeze vector, the fetch redirect and the front-stage flush. With
// PIPE_CTRL_IRQ_EN defined it also sequences interrupt entry: drain the pipe,
// save the resume PC into mepc, then redirect fetch to the trap vector.
// With PIPE_CTRL_IRQ_EN undefined the interrupt ports are ignored, the
// mepc/ack outputs are tied to 0 and the controller behaves as if always idle.
//
// Parameters:
//   DRAIN_CYCLES   minimum hold-free cycles spent draining EX/MEM (1..15)
//
// Ports:
//   clk             clock
//   rst_n           synchronous active-low reset
//   hold_id_i       load-use hazard in ID
//   hold_ex_i       multi-cycle EX op busy
//   hold_mem_i      data bus wait
//   ex_jump_flag_i  branch taken / jump resolved in EX
//   ex_jump_addr_i  target for ex_jump_flag_i
//   irq_i           level interrupt request
//   irq_en_i        global interrupt enable
//   irq_pc_i        PC of the instruction held in ID
//   mtvec_i         trap vector base
//   stall           per-stage freeze: [0] PC gen, [1] IF/PC, [2] IF/ID,
//                   [3] ID/EX, [4] EX/MEM, [5] MEM/WB
//   ctrl_jump_flag  redirect fetch this cycle
//   ctrl_jump_addr  redirect target
//   flush_o         squash IF/ID and ID/EX
//   mepc_we_o       one-cycle mepc write strobe
//   mepc_o          resume PC (0 when mepc_we_o is low)
//   irq_ack_o       one-cycle pulse when the trap redirect is taken
//   state_dbg       interrupt FSM state (0 IDLE, 1 DRAIN, 2 SAVE, 3 JUMP);
//                   always 0 when the interrupt logic is not built
//
// Handshake: there is no valid/ready pairing here; every output is a
// combinational function of the current inputs and the registered FSM state,
// valid in the same cycle the inputs are presented.

module pipe_ctrl #(
    parameter int DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hold_id_i,
    input  logic        hold_ex_i,
    input  logic        hold_mem_i,
    input  logic        ex_jump_flag_i,
    input  logic [31:0] ex_jump_addr_i,
    input  logic        irq_i,
    input  logic        irq_en_i,
    input  logic [31:0] irq_pc_i,
    input  logic [31:0] mtvec_i,
    output logic [5:0]  stall,
    output logic        ctrl_jump_flag,
    output logic [31:0] ctrl_jump_addr,
    output logic        flush_o,
    output logic        mepc_we_o,
    output logic [31:0] mepc_o,
    output logic        irq_ack_o,
    output logic [1:0]  state_dbg
);

    localparam logic [3:0] DRAIN_LIM = 4'(DRAIN_CYCLES);

    // A jump never fires while its EX instruction is frozen.
    logic jump_ok;
    assign jump_ok = ex_jump_flag_i & ~hold_ex_i & ~hold_mem_i;

    // Hold priority MEM > EX > ID. A taken jump flushes ID, which removes
    // the load-use pair, so hold_id is ignored when jump_ok is set.
    logic [5:0] hold_vec;
    always_comb begin
        hold_vec = 6'b000000;
        if (hold_mem_i) begin
            hold_vec = 6'b011111;
        end else if (hold_ex_i) begin
            hold_vec = 6'b001111;
        end else if (hold_id_i && !jump_ok) begin
            hold_vec = 6'b000111;
        end
    end

    // Pre-reset-mask output values.
    logic [5:0]  stall_c;
    logic        jump_flag_c;
    logic [31:0] jump_addr_c;
    logic        flush_c;
    logic        mepc_we_c;
    logic [31:0] mepc_c;
    logic        ack_c;

`ifdef PIPE_CTRL_IRQ_EN

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_SAVE  = 2'd2,
        S_JUMP  = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        pend_v, pend_v_nxt;
    logic [31:0] pend_pc, pend_pc_nxt;

    logic [3:0] cnt_inc;
    logic       drain_adv;
    assign cnt_inc   = cnt + 4'd1;
    assign drain_adv = ~hold_ex_i & ~hold_mem_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            pend_v  <= 1'b0;
            pend_pc <= 32'd0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            pend_v  <= pend_v_nxt;
            pend_pc <= pend_pc_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        pend_v_nxt  = pend_v;
        pend_pc_nxt = pend_pc;
        stall_c     = hold_vec;
        jump_flag_c = jump_ok;
        jump_addr_c = jump_ok ? ex_jump_addr_i : 32'd0;
        flush_c     = jump_ok;
        mepc_we_c   = 1'b0;
        mepc_c      = 32'd0;
        ack_c       = 1'b0;

        case (state)
            S_IDLE: begin
                if (irq_i && irq_en_i) begin
                    state_nxt = S_DRAIN;
                    cnt_nxt   = 4'd0;
                end
            end

            S_DRAIN: begin
                stall_c = hold_vec | 6'b000111;
                if (jump_ok) begin
                    // The jump target becomes the resume PC; the newly
                    // redirected stream needs a full drain again.
                    pend_pc_nxt = ex_jump_addr_i;
                    pend_v_nxt  = 1'b1;
                    cnt_nxt     = 4'd0;
                end else if (drain_adv) begin
                    cnt_nxt = cnt_inc;
                    // Leave on the edge where the count reaches the limit,
                    // giving DRAIN_CYCLES hold-free cycles in DRAIN.
                    if (cnt_inc == DRAIN_LIM) begin
                        state_nxt = S_SAVE;
                    end
                end
            end

            S_SAVE: begin
                stall_c   = hold_vec | 6'b000111;
                mepc_we_c = 1'b1;
                mepc_c    = pend_v ? pend_pc : irq_pc_i;
                state_nxt = S_JUMP;
            end

            S_JUMP: begin
                // Trap redirect wins over any EX jump; the flush also kills
                // any load-use pair in ID.
                stall_c     = hold_mem_i ? 6'b011111 :
                              hold_ex_i  ? 6'b001111 : 6'b000000;
                jump_flag_c = 1'b1;
                jump_addr_c = mtvec_i;
                flush_c     = 1'b1;
                ack_c       = 1'b1;
                pend_v_nxt  = 1'b0;
                state_nxt   = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign state_dbg = state;

`else

    logic unused_irq;
    assign unused_irq = ^{irq_i, irq_en_i, irq_pc_i, mtvec_i, DRAIN_LIM, clk};

    always_comb begin
        stall_c     = hold_vec;
        jump_flag_c = jump_ok;
        jump_addr_c = jump_ok ? ex_jump_addr_i : 32'd0;
        flush_c     = jump_ok;
        mepc_we_c   = 1'b0;
        mepc_c      = 32'd0;
        ack_c       = 1'b0;
    end

    assign state_dbg = 2'd0;

`endif

    // While reset is asserted everything is frozen and no side effects leak.
    always_comb begin
        if (!rst_n) begin
            stall          = 6'b111111;
            ctrl_jump_flag = 1'b0;
            ctrl_jump_addr = 32'd0;
            flush_o        = 1'b0;
            mepc_we_o      = 1'b0;
            mepc_o         = 32'd0;
            irq_ack_o      = 1'b0;
        end else begin
            stall          = stall_c;
            ctrl_jump_flag = jump_flag_c;
            ctrl_jump_addr = jump_addr_c;
            flush_o        = flush_c;
            mepc_we_o      = mepc_we_c;
            mepc_o         = mepc_c;
            irq_ack_o      = ack_c;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl -- directed bench for pipe_ctrl (DRAIN_CYCLES = 2).
// Expected outputs are hand-computed per vector and queued by the driver;
// a negedge monitor pops and compares. Interrupt expectations follow the
// PIPE_CTRL_IRQ_EN build option.

module tb_pipe_ctrl;

`ifdef PIPE_CTRL_IRQ_EN
    localparam bit IRQ = 1'b1;
`else
    localparam bit IRQ = 1'b0;
`endif

    localparam int W = 76;

    logic        clk;
    logic        rst_n;
    logic        hold_id_i;
    logic        hold_ex_i;
    logic        hold_mem_i;
    logic        ex_jump_flag_i;
    logic [31:0] ex_jump_addr_i;
    logic        irq_i;
    logic        irq_en_i;
    logic [31:0] irq_pc_i;
    logic [31:0] mtvec_i;
    logic [5:0]  stall;
    logic        ctrl_jump_flag;
    logic [31:0] ctrl_jump_addr;
    logic        flush_o;
    logic        mepc_we_o;
    logic [31:0] mepc_o;
    logic        irq_ack_o;
    logic [1:0]  state_dbg;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           checks;
    int           errors;

    pipe_ctrl #(.DRAIN_CYCLES(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .hold_id_i      (hold_id_i),
        .hold_ex_i      (hold_ex_i),
        .hold_mem_i     (hold_mem_i),
        .ex_jump_flag_i (ex_jump_flag_i),
        .ex_jump_addr_i (ex_jump_addr_i),
        .irq_i          (irq_i),
        .irq_en_i       (irq_en_i),
        .irq_pc_i       (irq_pc_i),
        .mtvec_i        (mtvec_i),
        .stall          (stall),
        .ctrl_jump_flag (ctrl_jump_flag),
        .ctrl_jump_addr (ctrl_jump_addr),
        .flush_o        (flush_o),
        .mepc_we_o      (mepc_we_o),
        .mepc_o         (mepc_o),
        .irq_ack_o      (irq_ack_o),
        .state_dbg      (state_dbg)
    );

    // Clock / reset block.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        rst_n          = 1'b0;
        hold_id_i      = 1'b0;
        hold_ex_i      = 1'b0;
        hold_mem_i     = 1'b0;
        ex_jump_flag_i = 1'b0;
        ex_jump_addr_i = 32'd0;
        irq_i          = 1'b0;
        irq_en_i       = 1'b0;
        irq_pc_i       = 32'h0000_0200;
        mtvec_i        = 32'h0000_0080;
    end

    // Driver: apply one cycle of inputs just after the rising edge and queue
    // the hand-computed response for that cycle.
    task automatic step(
        input logic        r,
        input logic        hid,
        input logic        hex,
        input logic        hmem,
        input logic        jf,
        input logic [31:0] ja,
        input logic        irq,
        input logic        en,
        input logic [5:0]  e_stall,
        input logic        e_jf,
        input logic [31:0] e_ja,
        input logic        e_flush,
        input logic        e_we,
        input logic [31:0] e_mepc,
        input logic        e_ack,
        input logic [1:0]  e_state,
        input string       name
    );
        @(posedge clk);
        #1;
        rst_n          = r;
        hold_id_i      = hid;
        hold_ex_i      = hex;
        hold_mem_i     = hmem;
        ex_jump_flag_i = jf;
        ex_jump_addr_i = ja;
        irq_i          = irq;
        irq_en_i       = en;
        exp_q.push_back({e_stall, e_jf, e_ja, e_flush, e_we, e_mepc, e_ack, e_state});
        name_q.push_back(name);
    endtask

    // Scoreboard monitor: sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            logic [W-1:0] e;
            logic [W-1:0] a;
            string        n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            a = {stall, ctrl_jump_flag, ctrl_jump_addr, flush_o, mepc_we_o,
                 mepc_o, irq_ack_o, state_dbg};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s got %h expected %h", n, a, e);
            end
        end
    end

    localparam logic [5:0]  ST_DR  = IRQ ? 6'h07 : 6'h00;
    localparam logic [1:0]  Q_DR   = IRQ ? 2'd1 : 2'd0;
    localparam logic [1:0]  Q_SV   = IRQ ? 2'd2 : 2'd0;
    localparam logic [1:0]  Q_JP   = IRQ ? 2'd3 : 2'd0;
    localparam logic [31:0] MTV    = IRQ ? 32'h80 : 32'h0;
    localparam logic [31:0] MEPC_A = IRQ ? 32'h200 : 32'h0;
    localparam logic [31:0] MEPC_B = IRQ ? 32'h300 : 32'h0;

    initial begin
        checks = 0;
        errors = 0;

        // Reset state
        step(0,0,0,0,0,0,     0,0, 6'h3F,0,0,0,0,0,0,0, "reset0");
        step(0,0,0,0,1,32'h44,1,1, 6'h3F,0,0,0,0,0,0,0, "reset1");

        // Hold priority
        step(1,0,0,0,0,0,     0,0, 6'h00,0,0,0,0,0,0,0, "no_hold");
        step(1,1,0,0,0,0,     0,0, 6'h07,0,0,0,0,0,0,0, "hold_id");
        step(1,1,1,0,0,0,     0,0, 6'h0F,0,0,0,0,0,0,0, "hold_id_ex");
        step(1,1,1,1,0,0,     0,0, 6'h1F,0,0,0,0,0,0,0, "hold_all");

        // Gated jump
        for (int i = 0; i < 3; i++)
            step(1,0,1,0,1,32'h100,0,0, 6'h0F,0,0,0,0,0,0,0, "jump_gated_ex");
        step(1,0,0,0,1,32'h100,0,0, 6'h00,1,32'h100,1,0,0,0,0, "jump_released");

        // Jump against load-use and against MEM/EX holds
        step(1,1,0,0,1,32'h104,0,0, 6'h00,1,32'h104,1,0,0,0,0, "jump_vs_loaduse");
        step(1,0,0,1,1,32'h108,0,0, 6'h1F,0,0,0,0,0,0,0, "jump_gated_mem");
        step(1,1,1,0,1,32'h10C,0,0, 6'h0F,0,0,0,0,0,0,0, "jump_gated_ex_id");

        // Masked interrupt
        step(1,0,0,0,0,0,     1,0, 6'h00,0,0,0,0,0,0,0, "irq_masked");
        step(1,0,0,0,0,0,     0,0, 6'h00,0,0,0,0,0,0,0, "irq_masked_idle");

        // Interrupt entry; irq drops during DRAIN without aborting
        step(1,0,0,0,0,0,     1,1, 6'h00,0,0,0,0,0,0,0, "irq_sample");
        step(1,0,0,0,0,0,     0,0, ST_DR,0,0,0,0,0,0,Q_DR, "irq_drain0");
        step(1,0,0,0,0,0,     0,0, ST_DR,0,0,0,0,0,0,Q_DR, "irq_drain1");
        step(1,0,0,0,0,0,     0,0, ST_DR,0,0,0,IRQ,MEPC_A,0,Q_SV, "irq_save");
        step(1,0,0,0,0,0,     0,0, 6'h00,IRQ,MTV,IRQ,0,0,IRQ,Q_JP, "irq_jump");
        step(1,0,0,0,0,0,     0,0, 6'h00,0,0,0,0,0,0,0, "irq_idle_after");

        // Jump in the 2nd DRAIN cycle restarts the drain, becomes mepc
        step(1,0,0,0,0,0,     1,1, 6'h00,0,0,0,0,0,0,0, "dj_sample");
        step(1,0,0,0,0,0,     0,0, ST_DR,0,0,0,0,0,0,Q_DR, "dj_drain0");
        step(1,0,0,0,1,32'h300,0,0, ST_DR,1,32'h300,1,0,0,0,Q_DR, "dj_jump");
        step(1,0,0,0,0,0,     0,0, ST_DR,0,0,0,0,0,0,Q_DR, "dj_restart0");
        step(1,0,0,0,0,0,     0,0, ST_DR,0,0,0,0,0,0,Q_DR, "dj_restart1");
        step(1,0,0,0,0,0,     0,0, ST_DR,0,0,0,IRQ,MEPC_B,0,Q_SV, "dj_save");
        step(1,0,0,0,0,0,     0,0, 6'h00,IRQ,MTV,IRQ,0,0,IRQ,Q_JP, "dj_ack");
        step(1,0,0,0,0,0,     0,0, 6'h00,0,0,0,0,0,0,0, "dj_idle");

        // Hold in DRAIN, pending PC cleared, back-to-back entry, reset in SAVE
        step(1,0,0,0,0,0,     1,1, 6'h00,0,0,0,0,0,0,0, "hd_sample");
        step(1,0,1,0,0,0,     0,0, 6'h0F,0,0,0,0,0,0,Q_DR, "hd_held");
        step(1,0,0,0,0,0,     0,0, ST_DR,0,0,0,0,0,0,Q_DR, "hd_drain0");
        step(1,0,0,0,0,0,     0,0, ST_DR,0,0,0,0,0,0,Q_DR, "hd_drain1");
        step(1,0,0,0,0,0,     0,0, ST_DR,0,0,0,IRQ,MEPC_A,0,Q_SV, "hd_save");
        step(1,0,0,0,0,0,     1,1, 6'h00,IRQ,MTV,IRQ,0,0,IRQ,Q_JP, "hd_ack");
        step(1,0,0,0,0,0,     1,1, 6'h00,0,0,0,0,0,0,0, "b2b_idle");
        step(1,0,0,0,0,0,     0,0, ST_DR,0,0,0,0,0,0,Q_DR, "b2b_drain0");
        step(1,0,0,0,0,0,     0,0, ST_DR,0,0,0,0,0,0,Q_DR, "b2b_drain1");
        step(0,0,0,0,0,0,     0,0, 6'h3F,0,0,0,0,0,0,Q_SV, "rst_in_save");
        step(0,0,0,0,0,0,     0,0, 6'h3F,0,0,0,0,0,0,0, "rst_held");
        step(1,0,0,0,0,0,     0,0, 6'h00,0,0,0,0,0,0,0, "rst_release");
        step(1,0,0,0,0,0,     0,0, 6'h00,0,0,0,0,0,0,0, "rst_no_ack");

        // Bounded wait for the monitor to drain the queue
        for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_queue got %0d pending expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
